// File: rtl/spi_csr_fifo_if.sv
// Bus bundle for spi_csr_fifo: SPI-slave CSR port, RX byte producer,
// TX byte consumer and the interrupt line.
interface spi_csr_fifo_if #(
  parameter int A_WIDTH = 5
) ();
  logic [A_WIDTH-1:0] csr_address;
  logic               csr_read;
  logic               csr_write;
  logic [7:0]         csr_writedata;
  logic [7:0]         csr_readdata;
  logic               rx_wr;
  logic [7:0]         rx_data;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               irq;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata, rx_wr, rx_data, tx_ready,
    input  csr_readdata, tx_valid, tx_data, irq
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata, rx_wr, rx_data, tx_ready,
    output csr_readdata, tx_valid, tx_data, irq
  );
endinterface

// File: rtl/spi_csr_fifo.sv
// CSR-mapped RX/TX byte FIFOs behind an SPI slave register bus,
// with sticky overflow flags and a registered level interrupt.
module spi_csr_fifo #(
  parameter int A_WIDTH    = 5,
  parameter int DEPTH_LOG2 = 4
) (
  input logic           clk,
  input logic           reset_n,
  spi_csr_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_CNT     = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [A_WIDTH-1:0]   ADDR_VERSION = A_WIDTH'(0);
  localparam logic [A_WIDTH-1:0]   ADDR_CTRL    = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0]   ADDR_STATUS  = A_WIDTH'(2);
  localparam logic [A_WIDTH-1:0]   ADDR_INT_CLR = A_WIDTH'(3);
  localparam logic [A_WIDTH-1:0]   ADDR_RX_CNT  = A_WIDTH'(4);
  localparam logic [A_WIDTH-1:0]   ADDR_TX_CNT  = A_WIDTH'(5);
  localparam logic [A_WIDTH-1:0]   ADDR_RX_DATA = A_WIDTH'(6);
  localparam logic [A_WIDTH-1:0]   ADDR_TX_DATA = A_WIDTH'(7);

  logic [7:0]            rx_mem_r [DEPTH];
  logic [7:0]            tx_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wptr_r, rx_rptr_r, tx_wptr_r, tx_rptr_r;
  logic [DEPTH_LOG2:0]   rx_cnt_r, tx_cnt_r;
  logic                  irq_en_r, rx_ovf_r, tx_ovf_r, irq_r;
  logic [7:0]            rdata_r, rdata_s;

  logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic wr_ctrl_s, wr_clr_s, wr_txdata_s, rd_rxdata_s;
  logic rx_flush_s, tx_flush_s;
  logic rx_push_s, rx_pop_s, rx_drop_s, tx_push_s, tx_pop_s, tx_drop_s;

  assign rx_empty_s  = (rx_cnt_r == '0);
  assign rx_full_s   = (rx_cnt_r == FULL_CNT);
  assign tx_empty_s  = (tx_cnt_r == '0);
  assign tx_full_s   = (tx_cnt_r == FULL_CNT);

  assign wr_ctrl_s   = bus.csr_write && (bus.csr_address == ADDR_CTRL);
  assign wr_clr_s    = bus.csr_write && (bus.csr_address == ADDR_INT_CLR);
  assign wr_txdata_s = bus.csr_write && (bus.csr_address == ADDR_TX_DATA);
  assign rd_rxdata_s = bus.csr_read  && (bus.csr_address == ADDR_RX_DATA);
  assign rx_flush_s  = wr_ctrl_s && bus.csr_writedata[0];
  assign tx_flush_s  = wr_ctrl_s && bus.csr_writedata[1];

  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign rx_pop_s    = rd_rxdata_s && !rx_empty_s;
  assign rx_push_s   = bus.rx_wr && (!rx_full_s || rx_pop_s);
  assign rx_drop_s   = bus.rx_wr && !rx_push_s;
  assign tx_pop_s    = !tx_empty_s && bus.tx_ready;
  assign tx_push_s   = wr_txdata_s && (!tx_full_s || tx_pop_s);
  assign tx_drop_s   = wr_txdata_s && !tx_push_s;

  assign bus.tx_valid     = !tx_empty_s;
  assign bus.tx_data      = tx_mem_r[tx_rptr_r];
  assign bus.csr_readdata = rdata_r;
  assign bus.irq          = irq_r;

  // FIFO storage, deliberately unreset.
  always_ff @(posedge clk) begin
    if (rx_push_s) begin
      rx_mem_r[rx_wptr_r] <= bus.rx_data;
    end
    if (tx_push_s) begin
      tx_mem_r[tx_wptr_r] <= bus.csr_writedata;
    end
  end

  // RX pointers and count; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr_r <= '0;
      rx_rptr_r <= '0;
      rx_cnt_r  <= '0;
    end else if (rx_flush_s) begin
      rx_wptr_r <= '0;
      rx_rptr_r <= '0;
      rx_cnt_r  <= '0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + 1'b1;
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + 1'b1;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + 1'b1;
        2'b01:   rx_cnt_r <= rx_cnt_r - 1'b1;
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // TX pointers and count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_r <= '0;
      tx_rptr_r <= '0;
      tx_cnt_r  <= '0;
    end else if (tx_flush_s) begin
      tx_wptr_r <= '0;
      tx_rptr_r <= '0;
      tx_cnt_r  <= '0;
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + 1'b1;
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + 1'b1;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + 1'b1;
        2'b01:   tx_cnt_r <= tx_cnt_r - 1'b1;
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // Register-map read mux.
  always_comb begin
    rdata_s = 8'h00;
    case (bus.csr_address)
      ADDR_VERSION: rdata_s = 8'h01;
      ADDR_CTRL:    rdata_s = {3'b000, irq_en_r, 4'b0000};
      ADDR_STATUS:  rdata_s = {2'b00, tx_ovf_r, rx_ovf_r, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
      ADDR_RX_CNT:  rdata_s = 8'(rx_cnt_r);
      ADDR_TX_CNT:  rdata_s = 8'(tx_cnt_r);
      ADDR_RX_DATA: begin
        if (rx_empty_s) rdata_s = 8'h00;
        else            rdata_s = rx_mem_r[rx_rptr_r];
      end
      default:      rdata_s = 8'h00;
    endcase
  end

  // Control/status registers; an overflow in the clearing cycle stays set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r  <= 8'h00;
      irq_en_r <= 1'b0;
      rx_ovf_r <= 1'b0;
      tx_ovf_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (bus.csr_read) rdata_r <= rdata_s;
      if (wr_ctrl_s)    irq_en_r <= bus.csr_writedata[4];
      rx_ovf_r <= rx_drop_s || (rx_ovf_r && !(wr_clr_s && bus.csr_writedata[4]));
      tx_ovf_r <= tx_drop_s || (tx_ovf_r && !(wr_clr_s && bus.csr_writedata[5]));
      irq_r    <= irq_en_r && (!rx_empty_s || rx_ovf_r || tx_ovf_r);
    end
  end
endmodule
